mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of both requesters and the memory port.
REQ-002 Parameter MEM_LAT, default 1, legal range 1..4: memory read latency in cycles from address to mem_rdata.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 core_req, core_we  input  1 each  core access request; write when core_we=1, read otherwise.
REQ-006 core_addr  input  ADDR_W  core address; core_wdata  input  32  core write data.
REQ-007 core_gnt, core_rvalid  output  1 each  core grant; core read-data-valid pulse.
REQ-008 core_rdata  output  32  core read data, qualified by core_rvalid.
REQ-009 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same directions, widths and meaning as the core_* set, for the DMA/loader requester.
REQ-010 mem_addr  output  ADDR_W; mem_wdata  output  32; mem_wren  output  1; mem_rdata  input  32: single-port memory interface.

Function
REQ-011 Requester SHALL hold req, we, addr and wdata stable from req assertion until the cycle its gnt is high; the arbiter SHALL NOT check this.
REQ-012 States: IDLE and RD_WAIT. At most one access SHALL be in flight.
REQ-013 gnt SHALL be combinational and asserted only in IDLE, for exactly one cycle, to the arbitration winner. In that same cycle mem_addr and mem_wdata SHALL carry the winner's fields, and mem_wren SHALL equal the winner's we.
REQ-014 Without a grant, mem_addr, mem_wdata and mem_wren SHALL be 0.
REQ-015 Write grant: the write completes in the grant cycle and the state SHALL remain IDLE. Back-to-back writes, one per cycle, SHALL be allowed.
REQ-016 Read grant in cycle T:
- The state SHALL go to RD_WAIT, storing the owner and loading a latency counter.
- The owner's rvalid SHALL pulse high for exactly one cycle, in cycle T+MEM_LAT.
- The state SHALL return to IDLE at T+MEM_LAT+1, the earliest cycle of the next grant.
REQ-017 mem_addr SHALL be held at the read address throughout RD_WAIT, with mem_wren=0.
REQ-018 core_rdata and dma_rdata SHALL both equal mem_rdata. Only the owner's rvalid SHALL assert; the non-owner's rvalid SHALL stay 0.
REQ-019 Requests arriving during RD_WAIT SHALL be held off (gnt=0) and arbitrated on return to IDLE.
REQ-020 Single pending request: that requester SHALL win.
REQ-021 A register last_owner SHALL record the winner of every grant.

Reset
REQ-022 While reset is high:
- The state SHALL be IDLE and the latency counter 0.
- last_owner SHALL be DMA.
- All gnt, rvalid, mem_wren and mem_* outputs SHALL be 0.
REQ-023 Reset asserted during RD_WAIT SHALL abort the read. No rvalid SHALL be issued for that read, including after reset deasserts.
REQ-024 After reset deasserts, the first grant is possible in the first clock edge cycle with a pending request.

Configuration
REQ-025 Macro MEM_ARBITER_ROUND_ROBIN_EN.
- Defined: when both requesters are pending in IDLE, the requester that is not last_owner SHALL win.
- Undefined: when both are pending, core SHALL always win, and last_owner SHALL be kept but unused.

Verification
REQ-026 Core read of addr 0x10, MEM_LAT=1, mem returns 0xDEADBEEF -> core_gnt at T, core_rvalid=1 with core_rdata=0xDEADBEEF at T+1, dma_rvalid=0, next grant no earlier than T+2.
REQ-027 Core and DMA both write continuously -> one mem_wren per cycle. With the macro defined, grants alternate core, dma, core. Without it, dma_gnt never asserts while core_req is high.
REQ-028 MEM_LAT=3, DMA read at T while core_req rises at T+1 -> core_gnt=0 through T+3, dma_rvalid at T+3, core_gnt at T+4.
REQ-029 Reset pulsed at T+1 during a MEM_LAT=3 core read granted at T -> all outputs 0 during reset, no core_rvalid afterwards, state IDLE.
REQ-030 Both requesters pending on the first cycle after reset -> core_gnt=1 in both configurations.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (core / DMA) arbiter in front of a single-port memory with MEM_LAT read latency.
// Optional: define MEM_ARBITER_ROUND_ROBIN_EN for round-robin on contention (default: core priority).
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [31:0]       core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [31:0]       core_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [31:0]       dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [31:0]       dma_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_wren,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic {IDLE, RD_WAIT} state_t;

   localparam logic       OWN_CORE = 1'b0;
   localparam logic       OWN_DMA  = 1'b1;
   // Counter holds the remaining RD_WAIT cycles; rvalid fires when it reaches 0.
   localparam logic [1:0] CNT_LOAD = 2'(MEM_LAT - 1);

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                owner_q, owner_d;
   logic                last_owner_q, last_owner_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

   logic                core_win, dma_win, any_win;
   logic                win_we;
   logic [ADDR_W-1:0]   win_addr;
   logic [31:0]         win_wdata;
   logic                rd_done;

   // Arbitration: only in IDLE, never while reset is asserted.
   always_comb begin
      core_win = 1'b0;
      dma_win  = 1'b0;
      if (state_q == IDLE && !reset) begin
         if (core_req && dma_req) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            if (last_owner_q == OWN_CORE) dma_win  = 1'b1;
            else                          core_win = 1'b1;
`else
            core_win = 1'b1;
`endif
         end else if (core_req) begin
            core_win = 1'b1;
         end else if (dma_req) begin
            dma_win = 1'b1;
         end
      end
   end

`ifndef MEM_ARBITER_ROUND_ROBIN_EN
   logic unused_last_owner;
   assign unused_last_owner = last_owner_q;
`endif

   assign any_win   = core_win | dma_win;
   assign win_we    = core_win ? core_we    : dma_we;
   assign win_addr  = core_win ? core_addr  : dma_addr;
   assign win_wdata = core_win ? core_wdata : dma_wdata;
   assign rd_done   = (state_q == RD_WAIT) && (cnt_q == 2'd0);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 2'd0;
         owner_q      <= OWN_CORE;
         last_owner_q <= OWN_DMA;
         rd_addr_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         rd_addr_q    <= rd_addr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      rd_addr_d    = rd_addr_q;
      case (state_q)
         IDLE: begin
            if (any_win) begin
               last_owner_d = dma_win ? OWN_DMA : OWN_CORE;
               if (!win_we) begin
                  state_d   = RD_WAIT;
                  cnt_d     = CNT_LOAD;
                  owner_d   = dma_win ? OWN_DMA : OWN_CORE;
                  rd_addr_d = win_addr;
               end
            end
         end
         RD_WAIT: begin
            if (cnt_q == 2'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 2'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      core_gnt    = core_win;
      dma_gnt     = dma_win;
      core_rvalid = rd_done && (owner_q == OWN_CORE);
      dma_rvalid  = rd_done && (owner_q == OWN_DMA);
      core_rdata  = reset ? 32'd0 : mem_rdata;
      dma_rdata   = reset ? 32'd0 : mem_rdata;
      mem_addr    = '0;
      mem_wdata   = 32'd0;
      mem_wren    = 1'b0;
      if (any_win) begin
         mem_addr  = win_addr;
         mem_wdata = win_wdata;
         mem_wren  = win_we;
      end else if (state_q == RD_WAIT) begin
         mem_addr  = rd_addr_q;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1 (u1), one with MEM_LAT=3 (u3), shared inputs.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        core_req = 1'b0, core_we = 1'b0;
   logic [31:0] core_addr = '0, core_wdata = '0;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] dma_addr = '0, dma_wdata = '0;
   logic [31:0] mem_rdata = '0;

   logic        u1_core_gnt, u1_core_rvalid, u1_dma_gnt, u1_dma_rvalid, u1_mem_wren;
   logic [31:0] u1_core_rdata, u1_dma_rdata, u1_mem_addr, u1_mem_wdata;
   logic        u3_core_gnt, u3_core_rvalid, u3_dma_gnt, u3_dma_rvalid, u3_mem_wren;
   logic [31:0] u3_core_rdata, u3_dma_rdata, u3_mem_addr, u3_mem_wdata;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .MEM_LAT(1)) u1 (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(u1_core_gnt), .core_rvalid(u1_core_rvalid), .core_rdata(u1_core_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(u1_dma_gnt), .dma_rvalid(u1_dma_rvalid), .dma_rdata(u1_dma_rdata),
      .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_wren(u1_mem_wren),
      .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.ADDR_W(32), .MEM_LAT(3)) u3 (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(u3_core_gnt), .core_rvalid(u3_core_rvalid), .core_rdata(u3_core_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(u3_dma_gnt), .dma_rvalid(u3_dma_rvalid), .dma_rdata(u3_dma_rdata),
      .mem_addr(u3_mem_addr), .mem_wdata(u3_mem_wdata), .mem_wren(u3_mem_wren),
      .mem_rdata(mem_rdata)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      core_req = 1'b0;
      dma_req  = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset;
      logic [100:0] obs;
      reset = 1'b1;
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'hA0; core_wdata = 32'h1234;
      dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 32'hB0;
      mem_rdata = 32'h5555_AAAA;
      tick();
      #1;
      obs = {u1_core_gnt, u1_dma_gnt, u1_core_rvalid, u1_dma_rvalid, u1_mem_wren, u1_mem_addr, u1_mem_wdata};
      vecs++;
      if (obs !== '0) begin errs++; $display("FAIL reset_u1_outs: got %h want 0", obs); end
      obs = {u3_core_gnt, u3_dma_gnt, u3_core_rvalid, u3_dma_rvalid, u3_mem_wren, u3_mem_addr, u3_mem_wdata};
      vecs++;
      if (obs !== '0) begin errs++; $display("FAIL reset_u3_outs: got %h want 0", obs); end
      core_req = 1'b0; dma_req = 1'b0;
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_core_read;
      mem_rdata = 32'hDEAD_BEEF;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
      #1;
      vecs++;
      if (u1_core_gnt !== 1'b1 || u1_dma_gnt !== 1'b0) begin
         errs++; $display("FAIL rd1_gnt: got core=%b dma=%b want core=1 dma=0", u1_core_gnt, u1_dma_gnt); end
      vecs++;
      if (u1_mem_addr !== 32'h10 || u1_mem_wren !== 1'b0) begin
         errs++; $display("FAIL rd1_mem: got addr=%h wren=%b want addr=10 wren=0", u1_mem_addr, u1_mem_wren); end
      tick();
      core_addr = 32'h20;
      #1;
      vecs++;
      if (u1_core_rvalid !== 1'b1 || u1_core_rdata !== 32'hDEAD_BEEF) begin
         errs++; $display("FAIL rd1_rvalid: got rv=%b data=%h want rv=1 data=deadbeef", u1_core_rvalid, u1_core_rdata); end
      vecs++;
      if (u1_dma_rvalid !== 1'b0 || u1_core_gnt !== 1'b0 || u1_mem_addr !== 32'h10) begin
         errs++; $display("FAIL rd1_wait: got dma_rv=%b gnt=%b addr=%h want 0 0 10", u1_dma_rvalid, u1_core_gnt, u1_mem_addr); end
      tick();
      #1;
      vecs++;
      if (u1_core_gnt !== 1'b1 || u1_mem_addr !== 32'h20 || u1_core_rvalid !== 1'b0) begin
         errs++; $display("FAIL rd1_next: got gnt=%b addr=%h rv=%b want 1 20 0", u1_core_gnt, u1_mem_addr, u1_core_rvalid); end
      tick();
      idle(10);
   endtask

   task automatic test_lat3_holdoff;
      mem_rdata = 32'hCAFE_F00D;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
      #1;
      vecs++;
      if (u3_dma_gnt !== 1'b1 || u3_mem_addr !== 32'h40) begin
         errs++; $display("FAIL l3_gnt: got gnt=%b addr=%h want 1 40", u3_dma_gnt, u3_mem_addr); end
      tick();
      dma_req = 1'b0;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h80;
      for (int c = 1; c <= 2; c++) begin
         #1;
         vecs++;
         if (u3_core_gnt !== 1'b0 || u3_dma_rvalid !== 1'b0 || u3_mem_addr !== 32'h40 || u3_mem_wren !== 1'b0) begin
            errs++; $display("FAIL l3_wait%0d: got gnt=%b rv=%b addr=%h wren=%b want 0 0 40 0",
                             c, u3_core_gnt, u3_dma_rvalid, u3_mem_addr, u3_mem_wren); end
         tick();
      end
      #1;
      vecs++;
      if (u3_core_gnt !== 1'b0 || u3_dma_rvalid !== 1'b1 || u3_core_rvalid !== 1'b0 || u3_dma_rdata !== 32'hCAFE_F00D) begin
         errs++; $display("FAIL l3_rvalid: got gnt=%b drv=%b crv=%b data=%h want 0 1 0 cafef00d",
                          u3_core_gnt, u3_dma_rvalid, u3_core_rvalid, u3_dma_rdata); end
      tick();
      #1;
      vecs++;
      if (u3_core_gnt !== 1'b1 || u3_mem_addr !== 32'h80 || u3_dma_rvalid !== 1'b0) begin
         errs++; $display("FAIL l3_next: got gnt=%b addr=%h drv=%b want 1 80 0", u3_core_gnt, u3_mem_addr, u3_dma_rvalid); end
      tick();
      idle(10);
   endtask

   task automatic test_reset_abort;
      logic [100:0] obs;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h30;
      #1;
      vecs++;
      if (u3_core_gnt !== 1'b1) begin errs++; $display("FAIL ab_gnt: got %b want 1", u3_core_gnt); end
      tick();
      reset = 1'b1;
      #1;
      obs = {u3_core_gnt, u3_dma_gnt, u3_core_rvalid, u3_dma_rvalid, u3_mem_wren, u3_mem_addr, u3_mem_wdata};
      vecs++;
      if (obs !== '0) begin errs++; $display("FAIL ab_reset_outs: got %h want 0", obs); end
      core_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         vecs++;
         if (u3_core_rvalid !== 1'b0 || u3_dma_rvalid !== 1'b0 || u3_mem_addr !== 32'h0) begin
            errs++; $display("FAIL ab_post%0d: got crv=%b drv=%b addr=%h want 0 0 0",
                             c, u3_core_rvalid, u3_dma_rvalid, u3_mem_addr); end
         tick();
      end
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h50; dma_wdata = 32'h55;
      #1;
      vecs++;
      if (u3_dma_gnt !== 1'b1 || u3_mem_wren !== 1'b1 || u3_mem_addr !== 32'h50 || u3_mem_wdata !== 32'h55) begin
         errs++; $display("FAIL ab_idle: got gnt=%b wren=%b addr=%h wd=%h want 1 1 50 55",
                          u3_dma_gnt, u3_mem_wren, u3_mem_addr, u3_mem_wdata); end
      tick();
      idle(3);
   endtask

   task automatic test_back_to_back;
      logic exp_core;
      reset = 1'b1;
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h100; core_wdata = 32'h1111_1111;
      dma_req  = 1'b1; dma_we  = 1'b1; dma_addr  = 32'h200; dma_wdata  = 32'h2222_2222;
      tick();
      tick();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         exp_core = (c % 2 == 0);
`else
         exp_core = 1'b1;
`endif
         #1;
         vecs++;
         if (u1_core_gnt !== exp_core || u1_dma_gnt !== !exp_core) begin
            errs++; $display("FAIL b2b_gnt%0d: got core=%b dma=%b want core=%b dma=%b",
                             c, u1_core_gnt, u1_dma_gnt, exp_core, !exp_core); end
         vecs++;
         if (u1_mem_wren !== 1'b1 || u1_mem_addr !== (exp_core ? 32'h100 : 32'h200) ||
             u1_mem_wdata !== (exp_core ? 32'h1111_1111 : 32'h2222_2222)) begin
            errs++; $display("FAIL b2b_mem%0d: got wren=%b addr=%h wd=%h core_exp=%b",
                             c, u1_mem_wren, u1_mem_addr, u1_mem_wdata, exp_core); end
         vecs++;
         if (u3_core_gnt !== exp_core || u3_mem_wren !== 1'b1) begin
            errs++; $display("FAIL b2b_u3_%0d: got gnt=%b wren=%b want %b 1", c, u3_core_gnt, u3_mem_wren, exp_core); end
         tick();
      end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_core_read();
      test_lat3_holdoff();
      test_reset_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
